hazard_pipe_ctrl: RTL
=====================

Name: hazard_pipe_ctrl

Overview:
- Central pipeline sequencer for the 5-stage 64-bit core. Drives the write-enable, flush and bubble controls of PC, IF/ID, ID/EX and EX/MEM, and the freeze of ID/EX, EX/MEM and MEM/WB.
- Handles four cases: load-use stalls, taken-branch flushes (resolved in MEM), data-memory wait freezes, and a halt drain sequence.
- Includes a memory watchdog and saturating stall/flush performance counters.

Parameters:
- MAX_WAIT, 16, maximum consecutive dmem_busy cycles before the watchdog trips.
- DRAIN_CYCLES, 3, non-frozen cycles spent in DRAIN before entering HALTED.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- ifid_rs1  in  5  rs1 field of the instruction in ID
- ifid_rs2  in  5  rs2 field of the instruction in ID
- ifid_uses_rs1  in  1  ID instruction reads rs1
- ifid_uses_rs2  in  1  ID instruction reads rs2
- idex_rd  in  5  destination register held in ID/EX
- idex_mem_read  in  1  MemRead control bit held in ID/EX
- branch_taken  in  1  taken branch resolved at EX/MEM
- dmem_busy  in  1  data memory not ready this cycle
- halt_req  in  1  halt instruction decoded in ID
- pc_write  out  1  PC load enable
- pc_src  out  1  1 = load the branch target
- ifid_write  out  1  IF/ID load enable
- ifid_flush  out  1  zero the IF/ID instruction
- idex_bubble  out  1  zero the WB/M/EX control bits entering ID/EX
- exmem_flush  out  1  zero the control bits entering EX/MEM
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB
- halted  out  1  core halted
- wdog_err  out  1  sticky memory-timeout error
- stall_count  out  CNT_W  load-use stall cycles
- flush_count  out  CNT_W  branch flush events

Behaviour:
- States: RUN, MEM_WAIT, DRAIN, HALTED. State and counters are registered; control outputs are combinational from state and inputs.
- Reset (asynchronous, any state, mid-operation included):
  - state = RUN; wait_cnt = 0; drain_cnt = 0.
  - Counters = 0; halted = 0; wdog_err = 0.
  - In RUN with all inputs 0: pc_write = 1, ifid_write = 1, all other control outputs 0.
- Load-use hazard (lu): idex_mem_read && idex_rd != 0 && ((ifid_uses_rs1 && ifid_rs1 == idex_rd) || (ifid_uses_rs2 && ifid_rs2 == idex_rd)).
- RUN decode, first matching case wins:
  1. dmem_busy: pipe_freeze = 1, pc_write = 0, ifid_write = 0, flush/bubble = 0. Next state MEM_WAIT, wait_cnt = 1.
  2. branch_taken: pc_src = 1, pc_write = 1, ifid_write = 1, ifid_flush = 1, idex_bubble = 1, exmem_flush = 1. flush_count += 1. halt_req and lu are ignored (younger instructions are squashed).
  3. halt_req: pc_write = 0, ifid_write = 0, ifid_flush = 1, idex_bubble = 1. Next state DRAIN, drain_cnt = DRAIN_CYCLES.
  4. lu: pc_write = 0, ifid_write = 0, idex_bubble = 1. stall_count += 1. Exactly one bubble per load-use.
  5. Otherwise: pc_write = 1, ifid_write = 1.
- MEM_WAIT:
  - dmem_busy = 1: freeze outputs as in RUN case 1; wait_cnt += 1. If wait_cnt == MAX_WAIT, set wdog_err = 1 and go to HALTED.
  - dmem_busy = 0: outputs and counter updates exactly as the RUN decode (cases 2–5) for this cycle. Next state RUN (or DRAIN, if case 3 fires); wait_cnt = 0.
- DRAIN:
  - Default outputs: pc_write = 0, ifid_write = 0, idex_bubble = 1.
  - dmem_busy = 1: freeze as in RUN case 1; drain_cnt unchanged; watchdog counts exactly as in MEM_WAIT.
  - branch_taken (no busy): apply RUN case 2 and return to RUN; the halt was on a wrong path.
  - Otherwise: drain_cnt -= 1. When drain_cnt reaches 0, go to HALTED.
- HALTED: pc_write = 0, ifid_write = 0, pipe_freeze = 1, halted = 1. All inputs are ignored; only reset exits.
- Counters saturate at 2^CNT_W − 1 and never wrap.
- wait_cnt width is clog2(MAX_WAIT + 1).
- Simultaneous events follow the priority above; pc_src is asserted only together with pc_write.

Test Plan:
1. Load-use: idex_mem_read = 1, idex_rd = 5, ifid_rs2 = 5, ifid_uses_rs2 = 1 → one cycle with pc_write = 0, ifid_write = 0, idex_bubble = 1; stall_count = 1. Same stimulus with idex_rd = 0 → no stall.
2. Branch over load-use: branch_taken = 1 while lu is true → pc_src = 1, ifid_flush = idex_bubble = exmem_flush = 1; flush_count = 1, stall_count = 0.
3. Memory wait: dmem_busy high for 4 cycles, then low with branch_taken = 1 → 4 cycles of pipe_freeze = 1, then flush in the release cycle; state returns to RUN.
4. Watchdog: dmem_busy held high, MAX_WAIT = 16 → wdog_err and halted rise after the 16th busy cycle; both stay high until reset.
5. Halt drain: halt_req pulse → 1 halt cycle + 3 DRAIN cycles with idex_bubble = 1, then halted = 1. Repeat with branch_taken on the 2nd DRAIN cycle → returns to RUN, halted stays 0.
6. Asynchronous reset asserted mid-DRAIN between clock edges → outputs return to reset values immediately; counters read 0.

Source files
------------

// File: rtl/hazard_pipe_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, branch flushes,
// data-memory freezes, halt drain, memory watchdog and stall/flush counters.
module hazard_pipe_ctrl #(
    parameter int MAX_WAIT     = 16,
    parameter int DRAIN_CYCLES = 3,
    parameter int CNT_W        = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       ifid_rs1,
    input  logic [4:0]       ifid_rs2,
    input  logic             ifid_uses_rs1,
    input  logic             ifid_uses_rs2,
    input  logic [4:0]       idex_rd,
    input  logic             idex_mem_read,
    input  logic             branch_taken,
    input  logic             dmem_busy,
    input  logic             halt_req,
    output logic             pc_write,
    output logic             pc_src,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             exmem_flush,
    output logic             pipe_freeze,
    output logic             halted,
    output logic             wdog_err,
    output logic [CNT_W-1:0] stall_count,
    output logic [CNT_W-1:0] flush_count
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int DRAIN_W = $clog2(DRAIN_CYCLES + 1);

    localparam logic [WAIT_W-1:0]  WAIT_MAX   = WAIT_W'(MAX_WAIT);
    localparam logic [WAIT_W-1:0]  WAIT_ONE   = WAIT_W'(1);
    localparam logic [WAIT_W-1:0]  WAIT_ZERO  = WAIT_W'(0);
    localparam logic [DRAIN_W-1:0] DRAIN_INIT = DRAIN_W'(DRAIN_CYCLES);
    localparam logic [DRAIN_W-1:0] DRAIN_ONE  = DRAIN_W'(1);
    localparam logic [DRAIN_W-1:0] DRAIN_ZERO = DRAIN_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ZERO   = CNT_W'(0);
    localparam logic [CNT_W-1:0]   CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0]   CNT_MAX    = {CNT_W{1'b1}};

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        DRAIN    = 2'd2,
        HALTED   = 2'd3
    } state_t;

    state_t             state_r;
    state_t             state_nxt_s;
    logic [WAIT_W-1:0]  wait_cnt_r;
    logic [WAIT_W-1:0]  wait_nxt_s;
    logic [WAIT_W-1:0]  wait_inc_s;
    logic [DRAIN_W-1:0] drain_cnt_r;
    logic [DRAIN_W-1:0] drain_nxt_s;
    logic               lu_s;
    logic               stall_inc_s;
    logic               flush_inc_s;
    logic               wdog_set_s;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] cnt, input logic en);
        logic [CNT_W-1:0] res;
        if (en && (cnt != CNT_MAX)) begin
            res = cnt + CNT_ONE;
        end else begin
            res = cnt;
        end
        return res;
    endfunction

    assign lu_s = idex_mem_read && (idex_rd != 5'd0) &&
                  ((ifid_uses_rs1 && (ifid_rs1 == idex_rd)) ||
                   (ifid_uses_rs2 && (ifid_rs2 == idex_rd)));

    assign wait_inc_s = wait_cnt_r + WAIT_ONE;

    // Next-state and pipeline control decode
    always_comb begin
        pc_write    = 1'b0;
        pc_src      = 1'b0;
        ifid_write  = 1'b0;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        exmem_flush = 1'b0;
        pipe_freeze = 1'b0;
        halted      = 1'b0;
        state_nxt_s = state_r;
        wait_nxt_s  = wait_cnt_r;
        drain_nxt_s = drain_cnt_r;
        stall_inc_s = 1'b0;
        flush_inc_s = 1'b0;
        wdog_set_s  = 1'b0;

        case (state_r)
            RUN, MEM_WAIT: begin
                if (dmem_busy) begin
                    pipe_freeze = 1'b1;
                    wait_nxt_s  = wait_inc_s;
                    if (wait_inc_s == WAIT_MAX) begin
                        wdog_set_s  = 1'b1;
                        state_nxt_s = HALTED;
                    end else begin
                        state_nxt_s = MEM_WAIT;
                    end
                end else begin
                    wait_nxt_s  = WAIT_ZERO;
                    state_nxt_s = RUN;
                    if (branch_taken) begin
                        pc_src      = 1'b1;
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc_s = 1'b1;
                    end else if (halt_req) begin
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        state_nxt_s = DRAIN;
                        drain_nxt_s = DRAIN_INIT;
                    end else if (lu_s) begin
                        idex_bubble = 1'b1;
                        stall_inc_s = 1'b1;
                    end else begin
                        pc_write   = 1'b1;
                        ifid_write = 1'b1;
                    end
                end
            end
            DRAIN: begin
                if (dmem_busy) begin
                    // Drain progress pauses while memory holds the back end.
                    pipe_freeze = 1'b1;
                    wait_nxt_s  = wait_inc_s;
                    if (wait_inc_s == WAIT_MAX) begin
                        wdog_set_s  = 1'b1;
                        state_nxt_s = HALTED;
                    end else begin
                        state_nxt_s = DRAIN;
                    end
                end else begin
                    wait_nxt_s = WAIT_ZERO;
                    if (branch_taken) begin
                        pc_src      = 1'b1;
                        pc_write    = 1'b1;
                        ifid_write  = 1'b1;
                        ifid_flush  = 1'b1;
                        idex_bubble = 1'b1;
                        exmem_flush = 1'b1;
                        flush_inc_s = 1'b1;
                        drain_nxt_s = DRAIN_ZERO;
                        state_nxt_s = RUN;
                    end else begin
                        idex_bubble = 1'b1;
                        drain_nxt_s = drain_cnt_r - DRAIN_ONE;
                        if (drain_cnt_r == DRAIN_ONE) begin
                            state_nxt_s = HALTED;
                        end else begin
                            state_nxt_s = DRAIN;
                        end
                    end
                end
            end
            HALTED: begin
                pipe_freeze = 1'b1;
                halted      = 1'b1;
            end
            default: begin
                state_nxt_s = RUN;
                wait_nxt_s  = WAIT_ZERO;
                drain_nxt_s = DRAIN_ZERO;
            end
        endcase
    end

    // State, memory-wait and drain counter registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= RUN;
            wait_cnt_r  <= WAIT_ZERO;
            drain_cnt_r <= DRAIN_ZERO;
        end else begin
            state_r     <= state_nxt_s;
            wait_cnt_r  <= wait_nxt_s;
            drain_cnt_r <= drain_nxt_s;
        end
    end

    // Performance counters and sticky watchdog flag
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stall_count <= CNT_ZERO;
            flush_count <= CNT_ZERO;
            wdog_err    <= 1'b0;
        end else begin
            stall_count <= sat_inc(stall_count, stall_inc_s);
            flush_count <= sat_inc(flush_count, flush_inc_s);
            wdog_err    <= wdog_err | wdog_set_s;
        end
    end

endmodule
